core_alu_exec: RTL

- Execute-stage ALU that consumes the 4-bit ALU operation code produced by the ALU control decoder, plus two 32-bit operands.
- Returns a registered result through a valid/ready handshake.
- Non-shift operations complete in one cycle. SLL/SRL/SRA run on a bit-serial shifter (one bit per cycle) to save area.
- Sits between the operand-select mux and the writeback stage of the RV32I pipeline.

---
 rtl/core_alu_exec.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/core_alu_exec.sv
// Execute-stage ALU with valid/ready handshake; shifts run bit-serially.
// Optional macro ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter instead.
module core_alu_exec #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [3:0]         OPCODE_ALU,
  input  logic [XLEN-1:0]    SRC1,
  input  logic [XLEN-1:0]    SRC2,
  input  logic [4:0]         RD_IN,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [XLEN-1:0]    ALU_RESULT,
  output logic [4:0]         RD_OUT,
  output logic               ALU_ILLEGAL
);

  localparam logic [3:0] ALU_CODE_ADD     = 4'h0;
  localparam logic [3:0] ALU_CODE_SUB     = 4'h1;
  localparam logic [3:0] ALU_CODE_SLL     = 4'h2;
  localparam logic [3:0] ALU_CODE_SLT     = 4'h3;
  localparam logic [3:0] ALU_CODE_SLTU    = 4'h4;
  localparam logic [3:0] ALU_CODE_XOR     = 4'h5;
  localparam logic [3:0] ALU_CODE_SRL     = 4'h6;
  localparam logic [3:0] ALU_CODE_SRA     = 4'h7;
  localparam logic [3:0] ALU_CODE_OR      = 4'h8;
  localparam logic [3:0] ALU_CODE_AND     = 4'h9;
  localparam logic [3:0] ALU_CODE_INVALID = 4'hF;

  typedef enum logic [1:0] {
    SK_SLL = 2'd0,
    SK_SRL = 2'd1,
    SK_SRA = 2'd2
  } shkind_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e            state_q;
  logic              valid_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_q;
  logic              illegal_q;

  logic [XLEN-1:0]   alu_res;
  logic              alu_ill;
  logic              is_shift;
  shkind_e           kind;
  logic [SHAMT_W-1:0] shamt;
  logic              accept;

  function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v, input shkind_e k);
    case (k)
      SK_SLL:  shift1 = {v[XLEN-2:0], 1'b0};
      SK_SRL:  shift1 = {1'b0, v[XLEN-1:1]};
      default: shift1 = {v[XLEN-1], v[XLEN-1:1]};
    endcase
  endfunction

  assign shamt    = SRC2[SHAMT_W-1:0];
  assign IN_READY = (state_q == IDLE) && (!valid_q || OUT_READY);
  assign accept   = IN_VALID && IN_READY;

  assign OUT_VALID   = valid_q;
  assign ALU_RESULT  = result_q;
  assign RD_OUT      = rd_q;
  assign ALU_ILLEGAL = illegal_q;

  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    kind     = SK_SLL;
    case (OPCODE_ALU)
      ALU_CODE_ADD:  alu_res = SRC1 + SRC2;
      ALU_CODE_SUB:  alu_res = SRC1 - SRC2;
      ALU_CODE_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(SRC1) < $signed(SRC2))};
      ALU_CODE_SLTU: alu_res = {{(XLEN-1){1'b0}}, (SRC1 < SRC2)};
      ALU_CODE_XOR:  alu_res = SRC1 ^ SRC2;
      ALU_CODE_OR:   alu_res = SRC1 | SRC2;
      ALU_CODE_AND:  alu_res = SRC1 & SRC2;
      ALU_CODE_SLL, ALU_CODE_SRL, ALU_CODE_SRA: begin
        is_shift = 1'b1;
        if (OPCODE_ALU == ALU_CODE_SRL)      kind = SK_SRL;
        else if (OPCODE_ALU == ALU_CODE_SRA) kind = SK_SRA;
`ifdef ALU_FAST_SHIFT_EN
        case (kind)
          SK_SLL:  alu_res = SRC1 << shamt;
          SK_SRL:  alu_res = SRC1 >> shamt;
          default: alu_res = $unsigned($signed(SRC1) >>> shamt);
        endcase
`else
        // Only shamt 0 and 1 resolve here; longer shifts go through SHIFT.
        alu_res = (shamt == '0) ? SRC1 : shift1(SRC1, kind);
`endif
      end
      ALU_CODE_INVALID: alu_ill = 1'b1;
      default:          alu_ill = 1'b1;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0]    work_q;
  logic [SHAMT_W-1:0] cnt_q;
  shkind_e            shk_q;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      work_q    <= '0;
      cnt_q     <= '0;
      shk_q     <= SK_SLL;
`endif
    end else begin
      if (valid_q && OUT_READY) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            rd_q <= RD_IN;
`ifndef ALU_FAST_SHIFT_EN
            // First shift happens at acceptance so a shift by n is valid n cycles later.
            if (is_shift && (shamt > SHAMT_W'(1))) begin
              work_q    <= shift1(SRC1, kind);
              cnt_q     <= shamt - SHAMT_W'(1);
              shk_q     <= kind;
              illegal_q <= 1'b0;
              state_q   <= SHIFT;
            end else
`endif
            begin
              result_q  <= alu_res;
              illegal_q <= alu_ill;
              valid_q   <= 1'b1;
            end
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        SHIFT: begin
          work_q <= shift1(work_q, shk_q);
          cnt_q  <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result_q <= shift1(work_q, shk_q);
            valid_q  <= 1'b1;
            state_q  <= HOLD;
          end
        end
`endif
        HOLD: begin
          if (valid_q && OUT_READY) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
